imm_encoder: RTL

Inverse of the ARM immediate extender: converts a 32-bit constant or branch target into the 24-bit instruction immediate field for a given ImmSrc class. Used by the program loader and self-test sequencer to build instruction words. Data-processing immediates need a rotation search, which runs iteratively at one rotation per cycle. Valid/ready handshake on both sides.

---
 rtl/imm_pkg.sv | 26 ++
 rtl/imm_rot_check.sv | 21 ++
 rtl/imm_encoder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared immediate-field definitions: ImmSrc classes, encoder FSM states and
// the branch-offset range helper used by both the extender and the encoder.
package imm_pkg;

    typedef enum logic [1:0] {
        IMM_DP  = 2'b00,
        IMM_MEM = 2'b01,
        IMM_BR  = 2'b10,
        IMM_RSV = 2'b11
    } imm_src_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } enc_state_t;

    localparam int ROT_STEPS = 16;

    // A branch offset is encodable when word aligned and representable as a
    // sign-extended 26-bit byte offset (24-bit word offset).
    function automatic logic br_offset_fits(input logic [31:0] off);
        return (off[1:0] == 2'b00) && (off[31:25] == {7{off[25]}});
    endfunction

endpackage : imm_pkg

// File: rtl/imm_rot_check.sv
// Tests one candidate rotation of a data-processing constant: rotates value
// left by 2*r and reports whether the result fits in an unsigned imm8.
module imm_rot_check
    import imm_pkg::*;
(
    input  logic [31:0] value,
    input  logic [3:0]  r,
    output logic [7:0]  t,
    output logic        fits
);

    logic [5:0]  sh;
    logic [31:0] rol;

    assign sh = {1'b0, r, 1'b0};
    // A right shift by 32 (sh == 0) yields zero, so r == 0 passes value through.
    assign rol  = (value << sh) | (value >> (6'd32 - sh));
    assign t    = rol[7:0];
    assign fits = (rol[31:8] == 24'd0);

endmodule : imm_rot_check

// File: rtl/imm_encoder.sv
// Encodes a 32-bit constant or branch target into the 24-bit ARM instruction
// immediate field; DP immediates search one rotation per cycle.
module imm_encoder
    import imm_pkg::*;
#(
    parameter int unsigned PC_AHEAD = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  imm_src,
    input  logic [31:0] value,
    input  logic [31:0] pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] field,
    output logic        ok
);

    localparam logic [3:0]  ROT_LAST    = 4'(ROT_STEPS - 1);
    localparam logic [31:0] PC_AHEAD_W  = 32'(PC_AHEAD);

    enc_state_t  state_q, state_d;
    imm_src_t    src_q, src_d;
    logic [3:0]  rot_q, rot_d;
    logic [31:0] value_q, value_d;
    logic [31:0] pc_q, pc_d;
    logic [23:0] field_q, field_d;
    logic        ok_q, ok_d;

    logic [7:0]  rot_t;
    logic        rot_fits;
    logic [31:0] br_off;

    imm_rot_check u_rot_check (
        .value (value_q),
        .r     (rot_q),
        .t     (rot_t),
        .fits  (rot_fits)
    );

    assign br_off = value_q - (pc_q + PC_AHEAD_W);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        src_d   = src_q;
        rot_d   = rot_q;
        value_d = value_q;
        pc_d    = pc_q;
        field_d = field_q;
        ok_d    = ok_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    src_d   = imm_src_t'(imm_src);
                    value_d = value;
                    pc_d    = pc;
                    rot_d   = 4'd0;
                    state_d = SEARCH;
                end
            end

            SEARCH: begin
                case (src_q)
                    IMM_DP: begin
                        if (rot_fits) begin
                            field_d = {12'd0, rot_q, rot_t};
                            ok_d    = 1'b1;
                            state_d = DONE;
                        end else if (rot_q == ROT_LAST) begin
                            field_d = 24'd0;
                            ok_d    = 1'b0;
                            state_d = DONE;
                        end else begin
                            rot_d = rot_q + 4'd1;
                        end
                    end
                    IMM_MEM: begin
                        ok_d    = (value_q[31:12] == 20'd0);
                        field_d = ok_d ? {12'd0, value_q[11:0]} : 24'd0;
                        state_d = DONE;
                    end
                    IMM_BR: begin
                        ok_d    = br_offset_fits(br_off);
                        field_d = ok_d ? br_off[25:2] : 24'd0;
                        state_d = DONE;
                    end
                    default: begin
                        field_d = 24'd0;
                        ok_d    = 1'b0;
                        state_d = DONE;
                    end
                endcase
            end

            DONE: begin
                if (out_ready) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            src_q   <= IMM_DP;
            rot_q   <= 4'd0;
            value_q <= 32'd0;
            pc_q    <= 32'd0;
            field_q <= 24'd0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            rot_q   <= rot_d;
            value_q <= value_d;
            pc_q    <= pc_d;
            field_q <= field_d;
            ok_q    <= ok_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign field     = field_q;
    assign ok        = ok_q;

endmodule : imm_encoder
